// File: rtl/dmc_pkg.sv
// dmc_pkg: shared widths, controller state encoding and address field helpers
// for the direct-mapped write-back cache controller.
// Optional feature macro used by the top: DMC_PERF_CNT_EN.
package dmc_pkg;
    localparam int ADDR_W = 17;
    localparam int LINE_W = 10;
    localparam int OFFS_W = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = ADDR_W - LINE_W - OFFS_W;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RESP, WB_REQ, WB_RD, WB_WR, RF_REQ, RF_DATA
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [LINE_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
        return a[OFFS_W +: LINE_W];
    endfunction

    function automatic logic [OFFS_W-1:0] addr_offs(input logic [ADDR_W-1:0] a);
        return a[OFFS_W-1:0];
    endfunction
endpackage

// File: rtl/dmc_tag_store.sv
// dmc_tag_store: per-line tag array with valid and dirty bit vectors.
// Ports: clk, rst_n (async active-low, clears valid/dirty only);
//   line                - line index for both the combinational read and the updates
//   tag, valid, dirty   - stored state of that line
//   fill, fill_tag      - install a new tag: valid=1, dirty=0
//   set_dirty, clr_dirty - mark / unmark the line as modified
module dmc_tag_store
    import dmc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line,
    output logic [TAG_W-1:0]  tag,
    output logic              valid,
    output logic              dirty,
    input  logic              fill,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic              set_dirty,
    input  logic              clr_dirty
);
    logic [TAG_W-1:0]     tags [2**LINE_W];
    logic [2**LINE_W-1:0] valid_q;
    logic [2**LINE_W-1:0] dirty_q;

    assign tag   = tags[line];
    assign valid = valid_q[line];
    assign dirty = dirty_q[line];

    // tags need no reset: they are meaningless until valid is set
    always_ff @(posedge clk)
        if (fill) tags[line] <= fill_tag;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill) valid_q[line] <= 1'b1;
            if (fill || clr_dirty) dirty_q[line] <= 1'b0;
            else if (set_dirty) dirty_q[line] <= 1'b1;
        end
endmodule

// File: rtl/dmc_wb_ctrl.sv
// dmc_wb_ctrl: sequencing controller for a direct-mapped write-back cache.
// Ports: clk, rst_n (async active-low);
//   cpu_req_*  - CPU request (valid/ready/we/addr/wdata), accepted only in IDLE
//   cpu_resp_* - one-cycle completion pulse with read data (0 for writes)
//   da_*       - external data array; da_rdata arrives one cycle after da_addr
//   mem_req_*  - burst request to main memory (we=1 writeback, we=0 refill)
//   mem_w*     - writeback beats with backpressure; mem_r* - refill beats, no backpressure
//   perf_hit/perf_miss/perf_wb - saturating event counters, present only when
//   DMC_PERF_CNT_EN is defined.
module dmc_wb_ctrl
    import dmc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req_valid,
    output logic                     cpu_req_ready,
    input  logic                     cpu_req_we,
    input  logic [ADDR_W-1:0]        cpu_req_addr,
    input  logic [DATA_W-1:0]        cpu_req_wdata,
    output logic                     cpu_resp_valid,
    output logic [DATA_W-1:0]        cpu_resp_rdata,
    output logic [LINE_W+OFFS_W-1:0] da_addr,
    output logic                     da_we,
    output logic [DATA_W-1:0]        da_wdata,
    input  logic [DATA_W-1:0]        da_rdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [TAG_W+LINE_W-1:0]  mem_req_blk,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_rvalid,
    input  logic [DATA_W-1:0]        mem_rdata
`ifdef DMC_PERF_CNT_EN
    ,
    output logic [31:0]              perf_hit,
    output logic [31:0]              perf_miss,
    output logic [31:0]              perf_wb
`endif
);
    state_t            state, next;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [OFFS_W-1:0] cnt;
    logic [TAG_W-1:0]  rtag, st_tag;
    logic [LINE_W-1:0] rline;
    logic [OFFS_W-1:0] roff;
    logic              st_valid, st_dirty, hit;
    logic              fill, set_dirty, clr_dirty, cnt_inc;

    assign rtag          = addr_tag(req_addr);
    assign rline         = addr_line(req_addr);
    assign roff          = addr_offs(req_addr);
    assign hit           = st_valid && st_tag == rtag;
    assign cpu_req_ready = state == IDLE;

    dmc_tag_store u_tags (
        .clk       (clk),
        .rst_n     (rst_n),
        .line      (rline),
        .tag       (st_tag),
        .valid     (st_valid),
        .dirty     (st_dirty),
        .fill      (fill),
        .fill_tag  (rtag),
        .set_dirty (set_dirty),
        .clr_dirty (clr_dirty)
    );

    always_comb begin
        next           = state;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        da_addr        = '0;
        da_we          = 1'b0;
        da_wdata       = '0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_blk    = '0;
        mem_wvalid     = 1'b0;
        mem_wdata      = '0;
        fill           = 1'b0;
        set_dirty      = 1'b0;
        clr_dirty      = 1'b0;
        cnt_inc        = 1'b0;
        case (state)
            IDLE: next = cpu_req_valid ? LOOKUP : IDLE;
            LOOKUP: begin
                da_addr = {rline, roff};
                if (hit) begin
                    da_we     = req_we;
                    da_wdata  = req_we ? req_wdata : '0;
                    set_dirty = req_we;
                    next      = RESP;
                end else begin
                    next = (st_valid && st_dirty) ? WB_REQ : RF_REQ;
                end
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_rdata = req_we ? '0 : da_rdata;
                next           = IDLE;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_blk   = {st_tag, rline};
                next          = mem_req_ready ? WB_RD : WB_REQ;
            end
            WB_RD: begin
                da_addr = {rline, cnt};
                next    = WB_WR;
            end
            WB_WR: begin
                // address stays on the array so its registered output holds during a stall
                da_addr    = {rline, cnt};
                mem_wvalid = 1'b1;
                mem_wdata  = da_rdata;
                if (mem_wready) begin
                    cnt_inc   = 1'b1;
                    clr_dirty = &cnt;
                    next      = &cnt ? RF_REQ : WB_RD;
                end
            end
            RF_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_blk   = {rtag, rline};
                next          = mem_req_ready ? RF_DATA : RF_REQ;
            end
            RF_DATA: begin
                if (mem_rvalid) begin
                    da_we    = 1'b1;
                    da_addr  = {rline, cnt};
                    da_wdata = mem_rdata;
                    cnt_inc  = 1'b1;
                    fill     = &cnt;
                    next     = &cnt ? LOOKUP : RF_DATA;
                end
            end
            default: next = IDLE;
        endcase
    end

    // cnt wraps to 0 after every 16-beat burst, so each burst starts from 0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            cnt       <= '0;
        end else begin
            state <= next;
            if (cpu_req_valid && cpu_req_ready) begin
                req_we    <= cpu_req_we;
                req_addr  <= cpu_req_addr;
                req_wdata <= cpu_req_wdata;
            end
            if (cnt_inc) cnt <= cnt + 1'b1;
        end

`ifdef DMC_PERF_CNT_EN
    // marks the LOOKUP that follows a refill so it is not counted as a hit
    logic replay;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            replay    <= 1'b0;
            perf_hit  <= '0;
            perf_miss <= '0;
            perf_wb   <= '0;
        end else begin
            replay <= fill ? 1'b1 : (state == LOOKUP ? 1'b0 : replay);
            if (state == LOOKUP && hit && !replay && ~&perf_hit) perf_hit <= perf_hit + 1'b1;
            if (state == LOOKUP && !hit && ~&perf_miss) perf_miss <= perf_miss + 1'b1;
            if (clr_dirty && ~&perf_wb) perf_wb <= perf_wb + 1'b1;
        end
`endif
endmodule

// File: tb/tb_dmc_wb_ctrl.sv
// tb_dmc_wb_ctrl: directed bench for dmc_wb_ctrl with a data array model and a
// main-memory model (block b, word j = j unless overwritten by a writeback).
module tb_dmc_wb_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [16:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic [13:0] da_addr;
    logic        da_we;
    logic [31:0] da_wdata, da_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [12:0] mem_req_blk;
    logic        mem_wvalid, mem_wready;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          total = 0;
    int          bad = 0;
    logic [31:0] da [16384];
    logic [31:0] mem_wr [int];
    logic [31:0] wbd [16];
    int          k, dly, st, wb_n, rf_n, nreq, lat;
    logic        rf_on, done, aborted, wbp;
    logic [31:0] resp;

    always #5 clk = ~clk;

    dmc_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
        .da_addr(da_addr), .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_blk(mem_req_blk),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (da_we) da[da_addr] <= da_wdata;
        da_rdata <= da[da_addr];
    end

    task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [12:0] blk, input int j);
        int key = int'(blk) * 16 + j;
        return mem_wr.exists(key) ? mem_wr[key] : 32'(j);
    endfunction

    task idle_outputs(input string tag);
        check({tag, "_ready"}, cpu_req_ready, 1);
        check({tag, "_strobes"}, {cpu_resp_valid, mem_req_valid, mem_req_we, mem_wvalid, da_we}, 0);
        check({tag, "_buses"}, {da_addr, mem_req_blk, cpu_resp_rdata}, 0);
        check({tag, "_data"}, {da_wdata, mem_wdata}, 0);
    endtask

    // one CPU transaction; the memory side is serviced here each negedge
    task run(input logic we, input logic [16:0] addr, input logic [31:0] wd,
             input logic wb, input logic [12:0] wb_blk, input logic [12:0] rf_blk,
             input int req_dly, input int st_beat, input int st_len, input int ab_beat,
             input int exp_nreq, input logic [31:0] exp_rd, input int exp_lat);
        k = 0; dly = 0; st = 0; wb_n = 0; rf_n = 0; nreq = 0;
        rf_on = 0; done = 0; aborted = 0;
        @(negedge clk);
        check("accept_ready", cpu_req_ready, 1);
        cpu_req_valid = 1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wd;
        @(posedge clk);
        while (!done && !aborted && k < 400) begin
            @(negedge clk);
            k++;
            cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
            if (cpu_resp_valid) begin
                done = 1; lat = k; resp = cpu_resp_rdata;
            end else if (rf_on && rf_n == ab_beat) begin
                mem_rvalid = 0; mem_req_ready = 0; mem_wready = 0;
                rst_n = 0;
                #1;
                idle_outputs("abort");
                aborted = 1;
            end else begin
                if (rf_on && rf_n < 16) begin
                    mem_rvalid = 1; mem_rdata = mem_word(rf_blk, rf_n); rf_n++;
                end else begin
                    mem_rvalid = 0; mem_rdata = 0;
                end
                wbp = wb && wb_n < 16;
                if (mem_req_valid) begin
                    check("req", {mem_req_we, mem_req_blk}, {wbp, wbp ? wb_blk : rf_blk});
                    if (dly < req_dly) begin
                        mem_req_ready = 0; dly++;
                    end else begin
                        mem_req_ready = 1; dly = 0; nreq++;
                        if (!wbp) rf_on = 1;
                    end
                end else mem_req_ready = 0;
                if (mem_wvalid) begin
                    if (wb_n == st_beat && st < st_len) begin
                        check("wdata_hold", mem_wdata, st_beat);
                        mem_wready = 0; st++;
                    end else begin
                        mem_wready = 1; wbd[wb_n] = mem_wdata;
                        mem_wr[int'(wb_blk) * 16 + wb_n] = mem_wdata; wb_n++;
                    end
                end else mem_wready = 0;
            end
        end
        mem_req_ready = 0; mem_wready = 0; mem_rvalid = 0; mem_rdata = 0;
        if (ab_beat < 0) begin
            check("resp_seen", done, 1);
            check("resp_rdata", resp, exp_rd);
            check("nreq", nreq, exp_nreq);
            check("wb_beats", wb_n, wb ? 16 : 0);
            check("rf_beats", rf_n, exp_nreq > 0 ? 16 : 0);
            if (exp_lat > 0) check("latency", lat, exp_lat);
            if (wb) check("wb_stall_len", st, st_beat >= 0 ? st_len : 0);
        end else begin
            check("aborted", aborted, 1);
            check("abort_beats", rf_n, ab_beat);
        end
    endtask

    initial begin
        rst_n = 0;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
        mem_req_ready = 0; mem_wready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        idle_outputs("reset_hold");
        rst_n = 1;
        @(negedge clk);
        idle_outputs("reset");
        // clean miss with full refill, then the same word hits
        run(0, 17'h00005, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 1, 32'd5, 20);
        run(0, 17'h00005, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 0, 32'd5, 2);
        // write hit dirties line 0, read it back
        run(1, 17'h00007, 32'hDEADBEEF, 0, 13'h000, 13'h000, 0, -1, 0, -1, 0, 32'd0, 2);
        run(0, 17'h00007, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 0, 32'hDEADBEEF, 2);
        // conflict on dirty line 0: writeback then refill of block 0x400
        run(0, 17'h04007, 0, 1, 13'h000, 13'h400, 0, -1, 0, -1, 2, 32'd7, 53);
        check("wb_beat7", wbd[7], 32'hDEADBEEF);
        check("wb_beat0", wbd[0], 32'd0);
        check("wb_beat15", wbd[15], 32'd15);
        // victim now clean: no writeback; written-back word comes back from memory
        run(0, 17'h00003, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 1, 32'd3, 20);
        run(0, 17'h00007, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 0, 32'hDEADBEEF, 2);
        // write miss on line 1 (refill then replayed write), then stalled writeback
        run(1, 17'h00019, 32'h12345678, 0, 13'h000, 13'h001, 0, -1, 0, -1, 1, 32'd0, 0);
        run(0, 17'h04014, 0, 1, 13'h001, 13'h401, 5, 4, 3, -1, 2, 32'd4, 0);
        check("wb1_beat4", wbd[4], 32'd4);
        check("wb1_beat9", wbd[9], 32'h12345678);
        check("wb1_beat15", wbd[15], 32'd15);
        // reset during refill beat 8, then the same read refills in full
        run(0, 17'h08025, 0, 0, 13'h000, 13'h802, 0, -1, 0, 8, 1, 32'd0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        idle_outputs("post_abort");
        run(0, 17'h08025, 0, 0, 13'h000, 13'h802, 0, -1, 0, -1, 1, 32'd5, 20);
        // reset cleared line 0 too: a former hit now misses
        run(0, 17'h00003, 0, 0, 13'h000, 13'h000, 0, -1, 0, -1, 1, 32'd3, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
